rift_wb_uart: RTL and testbench

- Wishbone-classic slave UART peripheral inside the rift2Wrap macro; sits directly on the wrapper's wbs_* slave bus and drives one io pad pair.
- Lets the management SoC exchange bytes with the outside world over 8N1 serial through TX and RX FIFOs.
- Raises user_irq when received data is pending.

---
 rtl/rift_wb_uart.sv | 142 ++++++++++++++
 tb/tb_rift_wb_uart.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rift_wb_uart.sv
// rift_wb_uart: Wishbone-classic slave 8N1 UART with TX/RX FIFOs and an rx-pending irq.
module rift_wb_uart #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd216
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        uart_oeb_o,
  output logic        irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] P1 = 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic hit, wr, rd, clr, en, irq_en, ovr, ferr;
  logic [1:0] ra;
  logic [15:0] div, tcnt, rcnt;
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic tx_empty, tx_full, rx_empty, rx_full, tx_push, tx_pop, rx_push, rx_pop;
  state_t tx_st, tx_nx, rx_st, rx_nx;
  logic [2:0] tbit, rbit, rs;
  logic [7:0] tsh, rsh;
  logic tx_bd, rx_bd, rxd, fall, rx_good, rx_ferr, ovr_set;
  logic [31:0] rdata;
  logic unused;
  assign unused = ^{wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_adr_i[1:0]};
  assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & !wbs_ack_o;
  assign wr  = hit & wbs_we_i;
  assign rd  = hit & !wbs_we_i;
  assign ra  = wbs_adr_i[3:2];
  assign clr = wr & (ra == 2'd3) & wbs_sel_i[0] & wbs_dat_i[2];
  assign tx_empty = tx_wp == tx_rp;
  assign tx_full  = tx_wp == {~tx_rp[AW], tx_rp[AW-1:0]};
  assign rx_empty = rx_wp == rx_rp;
  assign rx_full  = rx_wp == {~rx_rp[AW], rx_rp[AW-1:0]};
  assign tx_push  = wr & (ra == 2'd0) & wbs_sel_i[0] & !tx_full;
  assign rx_pop   = rd & (ra == 2'd0) & !rx_empty;
  assign uart_oeb_o = !en;
  assign uart_tx_o  = (tx_st == START) ? 1'b0 : (tx_st == DATA) ? tsh[0] : 1'b1;
  assign tx_bd = tcnt == 16'd0;
  always_comb begin
    tx_nx  = tx_st;
    tx_pop = 1'b0;
    if (!en) tx_nx = IDLE;
    else case (tx_st)
      IDLE:  if (!tx_empty) begin tx_nx = START; tx_pop = 1'b1; end
      START: if (tx_bd) tx_nx = DATA;
      DATA:  if (tx_bd && tbit == 3'd7) tx_nx = STOP;
      STOP:  if (tx_bd) tx_nx = IDLE;
    endcase
  end
  // rs[1] is the synchronized line, rs[2] its previous value for edge detection
  assign rxd   = rs[1];
  assign fall  = rs[2] & !rs[1];
  assign rx_bd = rcnt == 16'd0;
  always_comb begin
    rx_nx = rx_st;
    if (!en) rx_nx = IDLE;
    else case (rx_st)
      IDLE:  if (fall) rx_nx = START;
      START: if (rx_bd) rx_nx = rxd ? IDLE : DATA;
      DATA:  if (rx_bd && rbit == 3'd7) rx_nx = STOP;
      STOP:  if (rx_bd) rx_nx = IDLE;
    endcase
  end
  assign rx_good = en & (rx_st == STOP) & rx_bd & rxd;
  assign rx_ferr = en & (rx_st == STOP) & rx_bd & !rxd;
  // a same-cycle pop frees a slot, so a full FIFO only overruns without one
  assign rx_push = rx_good & (!rx_full | rx_pop);
  assign ovr_set = rx_good & rx_full & !rx_pop;
  always_comb
    rdata = (ra == 2'd0) ? (rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp[AW-1:0]]}) :
            (ra == 2'd1) ? {25'd0, ferr, tx_st != IDLE, ovr, rx_full, rx_empty, tx_empty, tx_full} :
            (ra == 2'd2) ? {16'd0, div} : {30'd0, irq_en, en};
  always_ff @(posedge wb_clk_i) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= wbs_dat_i[7:0];
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rsh;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_o <= 1'b0;
      en <= 1'b0;
      irq_en <= 1'b0;
      div <= DIV_RESET;
      ovr <= 1'b0;
      ferr <= 1'b0;
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
      tx_st <= IDLE;
      rx_st <= IDLE;
      tcnt <= '0;
      rcnt <= '0;
      tbit <= '0;
      rbit <= '0;
      tsh <= '0;
      rsh <= '0;
      rs <= 3'b111;
    end else begin
      wbs_ack_o <= hit;
      wbs_dat_o <= rd ? rdata : '0;
      irq_o <= irq_en & !rx_empty;
      if (wr && ra == 2'd2 && wbs_sel_i[0]) div[7:0] <= wbs_dat_i[7:0];
      if (wr && ra == 2'd2 && wbs_sel_i[1]) div[15:8] <= wbs_dat_i[15:8];
      if (wr && ra == 2'd3 && wbs_sel_i[0]) begin
        en <= wbs_dat_i[0];
        irq_en <= wbs_dat_i[1];
      end
      ovr <= ovr_set | (ovr & !clr);
      ferr <= rx_ferr | (ferr & !clr);
      if (tx_push) tx_wp <= tx_wp + P1;
      if (tx_pop) tx_rp <= tx_rp + P1;
      if (rx_push) rx_wp <= rx_wp + P1;
      if (rx_pop) rx_rp <= rx_rp + P1;
      tx_st <= tx_nx;
      rx_st <= rx_nx;
      tcnt <= (tx_st == IDLE || tx_bd) ? div : tcnt - 16'd1;
      rcnt <= (rx_st == IDLE) ? {1'b0, div[15:1]} : rx_bd ? div : rcnt - 16'd1;
      if (tx_pop) tsh <= tx_mem[tx_rp[AW-1:0]];
      else if (tx_st == DATA && tx_bd) tsh <= tsh >> 1;
      tbit <= (tx_st != DATA) ? 3'd0 : tx_bd ? tbit + 3'd1 : tbit;
      rbit <= (rx_st != DATA) ? 3'd0 : rx_bd ? rbit + 3'd1 : rbit;
      if (rx_st == DATA && rx_bd) rsh <= {rxd, rsh[7:1]};
      rs <= {rs[1:0], uart_rx_i};
    end
  end
endmodule

// File: tb/tb_rift_wb_uart.sv
// tb_rift_wb_uart: directed checks of bus, TX/RX framing, FIFOs, flags, irq and reset.
module tb_rift_wb_uart;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0, rx = 1'b1;
  logic [3:0] sel = 4'hF;
  logic [31:0] adr = '0, wdat = '0, dat_o;
  logic ack, tx, oeb, irq;
  int checks = 0, errors = 0;
  localparam logic [31:0] A_DATA = 32'h3000_0000, A_STAT = 32'h3000_0004,
                          A_DIV = 32'h3000_0008, A_CTRL = 32'h3000_000C;
  always #5 clk = ~clk;
  rift_wb_uart dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
    .uart_rx_i(rx), .uart_tx_o(tx), .uart_oeb_o(oeb), .irq_o(irq)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] r, output logic ok);
    ok = 1'b0;
    r = 'x;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack) begin ok = 1'b1; r = dat_o; break; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask
  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic ok;
    xfer(1'b1, a, d, r, ok);
    chk("write_ack", {31'd0, ok}, 32'd1);
  endtask
  task automatic wb_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic ok;
    xfer(1'b0, a, 32'd0, r, ok);
    chk("read_ack", {31'd0, ok}, 32'd1);
    chk(tag, r, exp);
  endtask
  // samples the TX line near the middle of each 4-cycle bit (DIV=3)
  task automatic tx_capture(output logic [7:0] b, output logic st, output logic sp, output logic ok);
    ok = 1'b0;
    b = '0; st = 1'b1; sp = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!tx) begin ok = 1'b1; break; end
    end
    if (ok) begin
      repeat (2) @(negedge clk);
      st = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        b[i] = tx;
      end
      repeat (4) @(negedge clk);
      sp = tx;
    end
  endtask
  task automatic send_frame(input logic [7:0] b, input logic sp);
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (4) @(negedge clk);
    end
    rx = sp;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] b;
    logic st, sp, ok;
    logic [31:0] r;
    logic [5:0] pat;
    int lows;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_oeb", {31'd0, oeb}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    wb_rd("rst_status", A_STAT, 32'h06);
    wb_rd("rst_div", A_DIV, 32'd216);
    wb_rd("rst_ctrl", A_CTRL, 32'd0);
    // single TX frame
    wb_wr(A_DIV, 32'd3);
    wb_rd("div_rb", A_DIV, 32'd3);
    wb_wr(A_CTRL, 32'd1);
    chk("en_oeb", {31'd0, oeb}, 32'd0);
    wb_wr(A_DATA, 32'hA5);
    tx_capture(b, st, sp, ok);
    chk("a5_seen", {31'd0, ok}, 32'd1);
    chk("a5_start", {31'd0, st}, 32'd0);
    chk("a5_byte", {24'd0, b}, 32'hA5);
    chk("a5_stop", {31'd0, sp}, 32'd1);
    repeat (4) @(negedge clk);
    wb_rd("a5_idle_status", A_STAT, 32'h06);
    // TX FIFO overflow with transmitter disabled
    wb_wr(A_CTRL, 32'd0);
    for (int i = 1; i <= 9; i++) wb_wr(A_DATA, i);
    wb_rd("txfull_status", A_STAT, 32'h05);
    wb_wr(A_CTRL, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      tx_capture(b, st, sp, ok);
      chk("txq_seen", {31'd0, ok}, 32'd1);
      chk("txq_byte", {24'd0, b}, i);
      chk("txq_stop", {31'd0, sp}, 32'd1);
    end
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    chk("txq_no_ninth", lows, 0);
    wb_rd("txq_status", A_STAT, 32'h06);
    // RX with irq
    wb_wr(A_CTRL, 32'd3);
    send_frame(8'h3C, 1'b1);
    chk("rx_irq_hi", {31'd0, irq}, 32'd1);
    wb_rd("rx_data", A_DATA, 32'h3C);
    @(posedge clk); #1;
    chk("rx_irq_lo", {31'd0, irq}, 32'd0);
    wb_rd("rx_empty_read", A_DATA, 32'd0);
    // overrun, frame error, sticky clear
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b1);
    wb_rd("ovr_status", A_STAT, 32'h1A);
    send_frame(8'h77, 1'b0);
    wb_rd("ferr_status", A_STAT, 32'h5A);
    for (int i = 0; i < 8; i++) wb_rd("ovr_data", A_DATA, 32'h10 + i);
    wb_rd("drained_status", A_STAT, 32'h56);
    wb_wr(A_CTRL, 32'd7);
    wb_rd("clr_status", A_STAT, 32'h06);
    wb_rd("clr_ctrl", A_CTRL, 32'd3);
    // bus protocol
    xfer(1'b0, 32'h3000_0010, 32'd0, r, ok);
    chk("miss_no_ack", {31'd0, ok}, 32'd0);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STAT;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pat = {pat[4:0], ack};
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    chk("held_ack_pattern", {26'd0, pat}, 32'b101010);
    // reset mid-frame
    wb_wr(A_DATA, 32'h00);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!tx) begin ok = 1'b1; break; end
    end
    chk("rst_mid_started", {31'd0, ok}, 32'd1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx_async", {31'd0, tx}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    chk("rst_mid_no_bits", lows, 0);
    wb_rd("rst_mid_status", A_STAT, 32'h06);
    wb_rd("rst_mid_div", A_DIV, 32'd216);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
